// File: rtl/bp_be_late_wb_arb.sv
// bp_be_late_wb_arb
//   Consumer side of the late-writeback valid/yumi interface. It arbitrates
//   round-robin among num_src_p long-latency sources and keeps the winner in
//   a one-entry holding register. That register drains into the shared
//   regfile late write port on any cycle the early writeback leaves the port
//   free. If a held write is blocked for starve_limit_p cycles, the block
//   asserts stall_o to request a writeback bubble.
//
//   The processor-config parameters are flattened into reg_addr_width_p and
//   dword_width_p. The packet is opaque to this block and passes through
//   unmodified. Its default layout is:
//   {late, ird_w_v, frd_w_v, fflags_w_v, rd_addr, rd_data, fflags[4:0]}.
//
//   Optional macro BP_LATE_WB_BYPASS_EN: when the holding register is empty
//   and the port is free, the winner goes straight to wb_pkt_o in the same
//   cycle and is not loaded into the holding register.
module bp_be_late_wb_arb #(
  parameter int num_src_p        = 2,
  parameter int starve_limit_p   = 7,
  parameter int reg_addr_width_p = 5,
  parameter int dword_width_p    = 64,
  localparam int wb_pkt_width_lp = 4 + reg_addr_width_p + dword_width_p + 5
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_src_p*wb_pkt_width_lp-1:0] wb_pkt_i,
  input  logic [num_src_p-1:0]                 v_i,
  output logic [num_src_p-1:0]                 yumi_o,
  input  logic                                 early_wb_busy_i,
  output logic [wb_pkt_width_lp-1:0]           wb_pkt_o,
  output logic                                 wb_v_o,
  output logic                                 stall_o,
  output logic                                 busy_o
);

  localparam int ptr_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;

  logic                       hold_v_q, hold_v_d;
  logic [wb_pkt_width_lp-1:0] hold_q, hold_d;
  logic [ptr_width_lp-1:0]    rr_q, rr_d;
  logic [7:0]                 starve_cnt_q, starve_cnt_d;

  logic                       win_v;
  logic [ptr_width_lp-1:0]    win_idx;
  logic [wb_pkt_width_lp-1:0] win_pkt;
  logic                       drain, accept_en, accept, bypass, load;
  int                         idx;

  // Round-robin pick: the first valid source at or after the rr pointer.
  always_comb begin
    win_v   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < num_src_p; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= num_src_p) idx = idx - num_src_p;
      if (!win_v && v_i[idx]) begin
        win_v   = 1'b1;
        win_idx = ptr_width_lp'(idx);
      end
    end
    win_pkt = wb_pkt_i[win_idx*wb_pkt_width_lp +: wb_pkt_width_lp];
  end

  // Drain/accept decisions, next-state values and outputs.
  always_comb begin
    drain     = hold_v_q & ~early_wb_busy_i;
    accept_en = ~hold_v_q | drain;
    bypass    = 1'b0;
`ifdef BP_LATE_WB_BYPASS_EN
    bypass    = ~hold_v_q & ~early_wb_busy_i & win_v & ~reset_i;
`endif
    // Nothing is accepted in a reset cycle: the sources are reset alongside us.
    accept    = accept_en & win_v & ~reset_i;
    load      = accept & ~bypass;

    hold_v_d  = load | (hold_v_q & ~drain);
    hold_d    = load ? win_pkt : hold_q;

    rr_d = rr_q;
    if (accept) begin
      rr_d = (int'(win_idx) == num_src_p - 1) ? '0 : win_idx + 1'b1;
    end

    starve_cnt_d = starve_cnt_q;
    if (drain) begin
      starve_cnt_d = '0;
    end else if (hold_v_q && early_wb_busy_i && (starve_cnt_q != 8'(starve_limit_p))) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    yumi_o = '0;
    if (accept) yumi_o[win_idx] = 1'b1;

    // A packet held at reset is discarded, so it must not commit in that cycle.
    wb_v_o   = (drain | bypass) & ~reset_i;
    busy_o   = hold_v_q & ~reset_i;
    stall_o  = hold_v_q & (starve_cnt_q == 8'(starve_limit_p)) & ~reset_i;
    wb_pkt_o = '0;
    if (!reset_i) begin
      if (bypass)        wb_pkt_o = win_pkt;
      else if (hold_v_q) wb_pkt_o = hold_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_v_q     <= 1'b0;
      hold_q       <= '0;
      rr_q         <= '0;
      starve_cnt_q <= '0;
    end else begin
      hold_v_q     <= hold_v_d;
      hold_q       <= hold_d;
      rr_q         <= rr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // At most one accept per cycle, and only to a source that is offering.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(yumi_o));
      assert ((yumi_o & ~v_i) == '0);
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_late_wb_arb.sv
// Testbench for bp_be_late_wb_arb: directed vector table, starvation
// sequences and randomized traffic against a queue-based reference model.
module tb_bp_be_late_wb_arb;

  localparam int N     = 2;
  localparam int LIMIT = 7;
  localparam int W     = 78;

  typedef struct packed {
    logic        late;
    logic        ird_w_v;
    logic        frd_w_v;
    logic        fflags_w_v;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic [4:0]  fflags;
  } pkt_t;

  typedef struct {
    logic         rst;
    logic [N-1:0] v;
    logic         busy;
    logic [N-1:0] e_yumi;
    logic         e_wbv;
    int           e_src;   // 0: wb_pkt_o zero, 1: P0, 2: P1
    logic         e_stall;
    logic         e_busy;
  } vec_t;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] wb_pkt_i;
  logic [N-1:0]   v_i;
  logic [N-1:0]   yumi_o;
  logic           early_wb_busy_i;
  logic [W-1:0]   wb_pkt_o;
  logic           wb_v_o, stall_o, busy_o;

  always #5 clk_i = ~clk_i;

  bp_be_late_wb_arb #(.num_src_p(N), .starve_limit_p(LIMIT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .wb_pkt_i(wb_pkt_i), .v_i(v_i),
    .yumi_o(yumi_o), .early_wb_busy_i(early_wb_busy_i), .wb_pkt_o(wb_pkt_o),
    .wb_v_o(wb_v_o), .stall_o(stall_o), .busy_o(busy_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: at most one held packet in a queue, the next source to favour,
  // and the number of cycles the held packet has been blocked.
  pkt_t held_q[$];
  int   m_rr  = 0;
  int   m_blk = 0;

  logic [N-1:0] a_yumi;
  logic         a_wbv, a_stall, a_busy;
  pkt_t         a_pkt;

  function automatic pkt_t mk_pkt(input int src, input logic [4:0] addr, input logic [63:0] data);
    pkt_t p;
    p = '0;
    p.late    = 1'b1;
    p.ird_w_v = (src == 0);
    p.frd_w_v = (src == 1);
    p.rd_addr = addr;
    p.rd_data = data;
    return p;
  endfunction

  function automatic pkt_t rnd_pkt();
    pkt_t p;
    p.late       = 1'($urandom);
    p.ird_w_v    = 1'($urandom);
    p.frd_w_v    = 1'($urandom);
    p.fflags_w_v = 1'($urandom);
    p.rd_addr    = 5'($urandom);
    p.rd_data    = {$urandom, $urandom};
    p.fflags     = 5'($urandom);
    return p;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic [N-1:0] v, input logic busy,
                               input logic [N-1:0] ey, input logic ew, input int es,
                               input logic est, input logic eb);
    vec_t t;
    t.rst = rst; t.v = v; t.busy = busy; t.e_yumi = ey; t.e_wbv = ew;
    t.e_src = es; t.e_stall = est; t.e_busy = eb;
    return t;
  endfunction

  // One clock: drive on the falling edge, sample 1ns later, check against the model,
  // then advance the model to the state after the next rising edge.
  task automatic step(input logic rst, input logic [N-1:0] v, input logic busy,
                      input pkt_t p0, input pkt_t p1);
    pkt_t         p[N];
    int           win, s;
    bit           held, drain, take, byp;
    logic [N-1:0] e_yumi;
    bit           e_wbv, e_stall, e_busy;
    pkt_t         e_pkt;
    p[0] = p0;
    p[1] = p1;
    @(negedge clk_i);
    reset_i         = rst;
    v_i             = v;
    early_wb_busy_i = busy;
    wb_pkt_i        = {p1, p0};
    #1;
    a_yumi = yumi_o; a_wbv = wb_v_o; a_stall = stall_o; a_busy = busy_o; a_pkt = wb_pkt_o;

    held = (held_q.size() != 0);
    drain = held && !busy;
    win = -1;
    for (int k = 0; k < N; k++) begin
      s = (m_rr + k) % N;
      if (win < 0 && v[s]) win = s;
    end
    take = !held || drain;
    byp = 1'b0;
`ifdef BP_LATE_WB_BYPASS_EN
    byp = !held && !busy && (win >= 0);
`endif
    e_yumi = '0;
    if (take && win >= 0) e_yumi[win] = 1'b1;
    e_wbv   = drain || byp;
    e_pkt   = byp ? p[win] : (held ? held_q[0] : '0);
    e_stall = held && (m_blk == LIMIT);
    e_busy  = held;
    if (rst) begin
      e_yumi = '0; e_wbv = 1'b0; e_pkt = '0; e_stall = 1'b0; e_busy = 1'b0;
    end

    chk("yumi",   128'(a_yumi),  128'(e_yumi));
    chk("wb_v",   128'(a_wbv),   128'(e_wbv));
    chk("wb_pkt", 128'(a_pkt),   128'(e_pkt));
    chk("stall",  128'(a_stall), 128'(e_stall));
    chk("busy",   128'(a_busy),  128'(e_busy));

    if (rst) begin
      held_q.delete();
      m_rr = 0;
      m_blk = 0;
    end else begin
      if (drain) m_blk = 0;
      else if (held && busy) m_blk = (m_blk < LIMIT) ? m_blk + 1 : LIMIT;
      if (drain) void'(held_q.pop_front());
      if (e_yumi != '0) begin
        if (!byp) held_q.push_back(p[win]);
        m_rr = (win + 1) % N;
      end
    end
  endtask

  pkt_t P0, P1, Z;
  vec_t tbl[$];

  initial begin
    P0 = mk_pkt(0, 5'd5, 64'h1234);
    P1 = mk_pkt(1, 5'd9, 64'hBEEF);
    Z  = '0;
    reset_i = 1'b1; v_i = '0; early_wb_busy_i = 1'b0; wb_pkt_i = '0;

    step(1, 2'b00, 0, Z, Z);
    step(1, 2'b11, 0, P0, P1);
    step(0, 2'b00, 0, Z, Z);

`ifndef BP_LATE_WB_BYPASS_EN
    //                rst v      busy yumi  wbv src stall busy
    tbl.push_back(mkv(0, 2'b01, 0, 2'b01, 0, 0, 0, 0));  // single packet
    tbl.push_back(mkv(0, 2'b00, 0, 2'b00, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 2'b00, 0, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 2'b11, 0, 2'b00, 0, 0, 0, 0));  // reset: rr back to 0
    tbl.push_back(mkv(0, 2'b11, 0, 2'b01, 0, 0, 0, 0));  // alternating back-to-back
    tbl.push_back(mkv(0, 2'b11, 0, 2'b10, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 2'b11, 0, 2'b01, 1, 2, 0, 1));
    tbl.push_back(mkv(0, 2'b11, 0, 2'b10, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 2'b00, 0, 2'b00, 1, 2, 0, 1));
    tbl.push_back(mkv(0, 2'b00, 0, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 2'b01, 0, 2'b01, 0, 0, 0, 0));  // held while blocked
    tbl.push_back(mkv(0, 2'b10, 1, 2'b00, 0, 1, 0, 1));
    tbl.push_back(mkv(0, 2'b10, 1, 2'b00, 0, 1, 0, 1));
    tbl.push_back(mkv(0, 2'b10, 0, 2'b10, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 2'b00, 0, 2'b00, 1, 2, 0, 1));
    tbl.push_back(mkv(0, 2'b00, 0, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 2'b01, 1, 2'b01, 0, 0, 0, 0));  // reset mid-operation
    tbl.push_back(mkv(1, 2'b11, 0, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 2'b11, 0, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 2'b00, 0, 2'b00, 1, 1, 0, 1));
    tbl.push_back(mkv(0, 2'b00, 0, 2'b00, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].busy, P0, P1);
      chk($sformatf("tbl%0d_yumi", i),  128'(a_yumi),  128'(tbl[i].e_yumi));
      chk($sformatf("tbl%0d_wbv", i),   128'(a_wbv),   128'(tbl[i].e_wbv));
      chk($sformatf("tbl%0d_pkt", i),   128'(a_pkt),
          (tbl[i].e_src == 1) ? 128'(P0) : (tbl[i].e_src == 2) ? 128'(P1) : 128'(0));
      chk($sformatf("tbl%0d_stall", i), 128'(a_stall), 128'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_busy", i),  128'(a_busy),  128'(tbl[i].e_busy));
    end

    // Starvation: 10 blocked cycles; stall appears once 7 blocked cycles have been counted.
    step(0, 2'b01, 0, P0, P1);
    for (int k = 1; k <= 10; k++) begin
      step(0, 2'b00, 1, P0, P1);
      chk($sformatf("starve_stall_%0d", k), 128'(a_stall), 128'(k >= LIMIT + 1));
      chk($sformatf("starve_wbv_%0d", k),   128'(a_wbv),   128'(0));
    end
    step(0, 2'b00, 0, P0, P1);
    chk("starve_drain_wbv", 128'(a_wbv), 128'(1));
    chk("starve_drain_pkt", 128'(a_pkt), 128'(P0));
    step(0, 2'b00, 0, P0, P1);
    chk("starve_after_stall", 128'(a_stall), 128'(0));
    chk("starve_after_busy",  128'(a_busy),  128'(0));

    // The counter restarted from zero: 7 blocked cycles without stall, then stall.
    step(0, 2'b01, 0, P0, P1);
    for (int k = 1; k <= LIMIT; k++) begin
      step(0, 2'b00, 1, P0, P1);
      chk($sformatf("restart_stall_%0d", k), 128'(a_stall), 128'(0));
    end
    step(0, 2'b00, 1, P0, P1);
    chk("restart_stall_hit", 128'(a_stall), 128'(1));
    step(0, 2'b00, 0, P0, P1);
    chk("restart_drain", 128'(a_wbv), 128'(1));
    step(0, 2'b00, 0, P0, P1);
`else
    step(0, 2'b01, 0, P0, P1);
    chk("byp_yumi", 128'(a_yumi), 128'(2'b01));
    chk("byp_wbv",  128'(a_wbv),  128'(1));
    chk("byp_pkt",  128'(a_pkt),  128'(P0));
    chk("byp_busy", 128'(a_busy), 128'(0));
    step(0, 2'b00, 0, P0, P1);
    chk("byp_idle_wbv",  128'(a_wbv),  128'(0));
    chk("byp_idle_busy", 128'(a_busy), 128'(0));
`endif

    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) == 0), N'($urandom), ($urandom_range(0, 99) < 40),
           rnd_pkt(), rnd_pkt());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
